regfile_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the 32 x 32-bit three-port register file (`register`). It serialises write and dual-read transactions from two requesters onto the register file's single port set, drives `EN`/`read`/`write`/select/data with correct timing, and returns read data with a valid strobe. It sits between the two datapath clients and the register file.

---
 rtl/regfile_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester round-robin sequencer for the 32x32 three-port register file
module regfile_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] wsel0,
  input  logic [AW-1:0] wsel1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [AW-1:0] rsel10,
  input  logic [AW-1:0] rsel20,
  input  logic [AW-1:0] rsel11,
  input  logic [AW-1:0] rsel21,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdataA0,
  output logic [DW-1:0] rdataB0,
  output logic [DW-1:0] rdataA1,
  output logic [DW-1:0] rdataB1,
  output logic          wzero,
  output logic          busy,
  output logic          rf_EN,
  output logic          rf_read,
  output logic          rf_write,
  output logic [AW-1:0] rf_selectW1,
  output logic [AW-1:0] rf_selectR1,
  output logic [AW-1:0] rf_selectR2,
  output logic [DW-1:0] rf_addr,
  input  logic [DW-1:0] rf_outA,
  input  logic [DW-1:0] rf_outB
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state;
  logic          last;
  logic          cmd_who;
  logic          cmd_we;

  logic          win;
  logic          sel_we;
  logic [AW-1:0] sel_wsel;
  logic [DW-1:0] sel_wdata;
  logic [AW-1:0] sel_rsel1;
  logic [AW-1:0] sel_rsel2;

  // Under contention the requester not granted last wins; a lone request always wins.
  always_comb begin
    win       = (req0 & req1) ? ~last : req1;
    sel_we    = win ? we1    : we0;
    sel_wsel  = win ? wsel1  : wsel0;
    sel_wdata = win ? wdata1 : wdata0;
    sel_rsel1 = win ? rsel11 : rsel10;
    sel_rsel2 = win ? rsel21 : rsel20;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      cmd_who     <= 1'b0;
      cmd_we      <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdataA0     <= '0;
      rdataB0     <= '0;
      rdataA1     <= '0;
      rdataB1     <= '0;
      wzero       <= 1'b0;
      busy        <= 1'b0;
      rf_EN       <= 1'b0;
      rf_read     <= 1'b0;
      rf_write    <= 1'b0;
      rf_selectW1 <= '0;
      rf_selectR1 <= '0;
      rf_selectR2 <= '0;
      rf_addr     <= '0;
    end else begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      wzero       <= 1'b0;
      rf_EN       <= 1'b0;
      rf_read     <= 1'b0;
      rf_write    <= 1'b0;
      rf_selectW1 <= '0;
      rf_selectR1 <= '0;
      rf_selectR2 <= '0;
      rf_addr     <= '0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            last        <= win;
            cmd_who     <= win;
            cmd_we      <= sel_we;
            gnt0        <= ~win;
            gnt1        <= win;
            // The rf_* registers double as the latched command seen during ISSUE.
            rf_EN       <= 1'b1;
            rf_read     <= ~sel_we;
            rf_write    <= sel_we & (sel_wsel != '0);
            wzero       <= sel_we & (sel_wsel == '0);
            rf_selectW1 <= sel_wsel;
            rf_selectR1 <= sel_rsel1;
            rf_selectR2 <= sel_rsel2;
            rf_addr     <= sel_wdata;
          end
        end
        ISSUE: begin
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!cmd_we) begin
            if (cmd_who) begin
              rdataA1 <= rf_outA;
              rdataB1 <= rf_outB;
              rvalid1 <= 1'b1;
            end else begin
              rdataA0 <= rf_outA;
              rdataB0 <= rf_outB;
              rvalid0 <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
